ebox_mem_req: RTL and testbench

- EBOX-side initiator for the EBOX↔MBOX cache memory-reference handshake. It is the requesting end of the protocol the cache controller answers.
- It accepts one microcode memory start and drives EBOX_REQ with the VMA_READ, VMA_WRITE and VMA_PAUSE qualifiers. It then waits for MBOX_RESP and generates EBOX_SYNC to close the cycle.
- It handles retry, page fail, abort and the read-pause-write second half, and times out on a missing response.
- It sits between MCL (microcode memory control) and the MBOX cache/arbiter.

---
 rtl/mbox_pkg.sv | 23 ++
 rtl/ebox_req_timer.sv | 49 ++++
 rtl/ebox_mem_req.sv | 209 ++++++++++++++++++++
 tb/tb_ebox_mem_req.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mbox_pkg.sv
// Shared types and defaults for the EBOX side of the EBOX<->MBOX memory-reference handshake.
package mbox_pkg;

    localparam int unsigned TIMEOUT_DEF   = 1024;
    localparam int unsigned MAX_RETRY_DEF = 15;
    localparam int unsigned RETRY_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SYNC,
        ST_PAUSE,
        ST_FAIL
    } ebox_req_state_t;

    typedef struct packed {
        logic read;
        logic write;
        logic pause;
    } mem_op_t;

endpackage

// File: rtl/ebox_req_timer.sv
// Response-timeout counter and saturating per-reference retry counter.
module ebox_req_timer
    import mbox_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tmo_clr_i,
    input  logic               tmo_en_i,
    input  logic               rty_clr_i,
    input  logic               rty_inc_i,
    output logic               tmo_expired_o,
    output logic               rty_exhausted_o,
    output logic [RETRY_W-1:0] rty_cnt_o
);

    localparam int unsigned        TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]      TMO_SAT  = '1;
    localparam logic [RETRY_W-1:0] RTY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RTY_SAT  = '1;

    logic [TW-1:0]      tmo_q;
    logic [RETRY_W-1:0] rty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            rty_q <= '0;
        end else begin
            if (tmo_clr_i)
                tmo_q <= '0;
            else if (tmo_en_i && tmo_q != TMO_SAT)
                tmo_q <= tmo_q + 1'b1;

            if (rty_clr_i)
                rty_q <= '0;
            else if (rty_inc_i && rty_q != RTY_SAT)
                rty_q <= rty_q + 1'b1;
        end
    end

    assign tmo_expired_o   = (tmo_q >= TMO_LAST);
    assign rty_exhausted_o = (rty_q >= RTY_LAST);
    assign rty_cnt_o       = rty_q;

endmodule

// File: rtl/ebox_mem_req.sv
// EBOX-side initiator: issues one memory reference to the MBOX, syncs the response,
// and handles retry, page fail, abort, timeout and the read-pause-write second half.
module ebox_mem_req
    import mbox_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
    parameter int unsigned DW        = 36,
    parameter int unsigned AW        = 23
) (
    input  logic               clk,
    input  logic               RESET_n,
    input  logic               START,
    input  logic               OP_READ,
    input  logic               OP_WRITE,
    input  logic               OP_PAUSE,
    input  logic [AW-1:0]      VMA_IN,
    input  logic [DW-1:0]      WR_DATA,
    input  logic               WR_GO,
    input  logic               ABORT,
    input  logic               MBOX_RESP,
    input  logic               EBOX_RETRY_REQ,
    input  logic               PAGE_FAIL_HOLD,
    input  logic [DW-1:0]      MB_RD_DATA,
    output logic               EBOX_REQ,
    output logic               VMA_READ,
    output logic               VMA_WRITE,
    output logic               VMA_PAUSE,
    output logic [AW-1:0]      VMA_OUT,
    output logic [DW-1:0]      EB_WR_DATA,
    output logic               EBOX_SYNC,
    output logic               EBOX_CYC_ABORT,
    output logic               BUSY,
    output logic               DONE,
    output logic [DW-1:0]      RD_DATA,
    output logic               PAGE_FAIL,
    output logic               NXM_ERR,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    ebox_req_state_t state_q, state_d;
    mem_op_t         op_q, op_d;
    logic            half_q, half_d;
    logic            gap_q, gap_d;
    logic            abort_q, abort_d;
    logic            noop_q, noop_d;
    logic            pf_q, pf_d;
    logic            nxm_q, nxm_d;
    logic [AW-1:0]   vma_q, vma_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic rty_clr, rty_inc, tmo_expired, rty_exhausted;
    logic active, rd_qual;

    ebox_req_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_timer (
        .clk             (clk),
        .rst_n           (RESET_n),
        .tmo_clr_i       (state_q != ST_WAIT),
        .tmo_en_i        (state_q == ST_WAIT),
        .rty_clr_i       (rty_clr),
        .rty_inc_i       (rty_inc),
        .tmo_expired_o   (tmo_expired),
        .rty_exhausted_o (rty_exhausted),
        .rty_cnt_o       (RETRY_CNT)
    );

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            half_q  <= 1'b0;
            gap_q   <= 1'b0;
            abort_q <= 1'b0;
            noop_q  <= 1'b0;
            pf_q    <= 1'b0;
            nxm_q   <= 1'b0;
            vma_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            noop_q  <= noop_d;
            pf_q    <= pf_d;
            nxm_q   <= nxm_d;
            vma_q   <= vma_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // A pause reference reads in its first half and writes in its second half.
    assign active  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign rd_qual = active && (op_q.pause ? !half_q : op_q.read);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        half_d  = half_q;
        gap_d   = 1'b0;
        abort_d = 1'b0;
        noop_d  = 1'b0;
        pf_d    = pf_q;
        nxm_d   = nxm_q;
        vma_d   = vma_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rty_clr = 1'b0;
        rty_inc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    pf_d    = 1'b0;
                    nxm_d   = 1'b0;
                    rty_clr = 1'b1;
                    if (OP_READ || OP_WRITE) begin
                        op_d.read  = OP_READ;
                        op_d.write = OP_WRITE;
                        op_d.pause = OP_PAUSE && OP_READ && OP_WRITE;
                        half_d     = 1'b0;
                        vma_d      = VMA_IN;
                        if (OP_WRITE && !OP_READ)
                            wdata_d = WR_DATA;
                        state_d = ST_REQ;
                    end else begin
                        noop_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (!gap_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (PAGE_FAIL_HOLD) begin
                    pf_d    = 1'b1;
                    state_d = ST_FAIL;
                end else if (MBOX_RESP) begin
                    if (rd_qual)
                        rdata_d = MB_RD_DATA;
                    state_d = ST_SYNC;
                end else if (EBOX_RETRY_REQ) begin
                    if (rty_exhausted) begin
                        nxm_d   = 1'b1;
                        state_d = ST_FAIL;
                    end else begin
                        rty_inc = 1'b1;
                        gap_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (tmo_expired) begin
                    nxm_d   = 1'b1;
                    state_d = ST_FAIL;
                end
            end
            ST_SYNC: begin
                state_d = (op_q.pause && !half_q) ? ST_PAUSE : ST_IDLE;
            end
            ST_PAUSE: begin
                if (ABORT) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (WR_GO) begin
                    wdata_d = WR_DATA;
                    half_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The retry gap holds REQ for one extra cycle with the request deasserted.
    assign EBOX_REQ       = active && !gap_q;
    assign VMA_READ       = rd_qual;
    assign VMA_WRITE      = active && (op_q.pause ? half_q : op_q.write);
    assign VMA_PAUSE      = active && op_q.pause && !half_q;
    assign VMA_OUT        = vma_q;
    assign EB_WR_DATA     = wdata_q;
    assign EBOX_SYNC      = (state_q == ST_SYNC);
    assign EBOX_CYC_ABORT = abort_q;
    assign BUSY           = (state_q != ST_IDLE);
    assign DONE           = ((state_q == ST_SYNC) && !(op_q.pause && !half_q))
                            || (state_q == ST_FAIL) || noop_q;
    assign RD_DATA        = rdata_q;
    assign PAGE_FAIL      = pf_q;
    assign NXM_ERR        = nxm_q;

endmodule

// File: tb/tb_ebox_mem_req.sv
// Directed self-checking bench for ebox_mem_req (TIMEOUT overridden to 8).
module tb_ebox_mem_req;

    localparam int unsigned DW = 36;
    localparam int unsigned AW = 23;

    logic          clk = 1'b0;
    logic          RESET_n = 1'b0;
    logic          START = 1'b0, OP_READ = 1'b0, OP_WRITE = 1'b0, OP_PAUSE = 1'b0;
    logic [AW-1:0] VMA_IN = '0;
    logic [DW-1:0] WR_DATA = '0, MB_RD_DATA = '0;
    logic          WR_GO = 1'b0, ABORT = 1'b0, MBOX_RESP = 1'b0;
    logic          EBOX_RETRY_REQ = 1'b0, PAGE_FAIL_HOLD = 1'b0;
    logic          EBOX_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE;
    logic [AW-1:0] VMA_OUT;
    logic [DW-1:0] EB_WR_DATA, RD_DATA;
    logic          EBOX_SYNC, EBOX_CYC_ABORT, BUSY, DONE, PAGE_FAIL, NXM_ERR;
    logic [3:0]    RETRY_CNT;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ebox_mem_req #(
        .TIMEOUT   (8),
        .MAX_RETRY (15),
        .DW        (DW),
        .AW        (AW)
    ) dut (
        .clk            (clk),
        .RESET_n        (RESET_n),
        .START          (START),
        .OP_READ        (OP_READ),
        .OP_WRITE       (OP_WRITE),
        .OP_PAUSE       (OP_PAUSE),
        .VMA_IN         (VMA_IN),
        .WR_DATA        (WR_DATA),
        .WR_GO          (WR_GO),
        .ABORT          (ABORT),
        .MBOX_RESP      (MBOX_RESP),
        .EBOX_RETRY_REQ (EBOX_RETRY_REQ),
        .PAGE_FAIL_HOLD (PAGE_FAIL_HOLD),
        .MB_RD_DATA     (MB_RD_DATA),
        .EBOX_REQ       (EBOX_REQ),
        .VMA_READ       (VMA_READ),
        .VMA_WRITE      (VMA_WRITE),
        .VMA_PAUSE      (VMA_PAUSE),
        .VMA_OUT        (VMA_OUT),
        .EB_WR_DATA     (EB_WR_DATA),
        .EBOX_SYNC      (EBOX_SYNC),
        .EBOX_CYC_ABORT (EBOX_CYC_ABORT),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .RD_DATA        (RD_DATA),
        .PAGE_FAIL      (PAGE_FAIL),
        .NXM_ERR        (NXM_ERR),
        .RETRY_CNT      (RETRY_CNT)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ref(input logic rd, input logic wr, input logic ps, input logic [AW-1:0] vma);
        START = 1'b1; OP_READ = rd; OP_WRITE = wr; OP_PAUSE = ps; VMA_IN = vma;
        tick();
        START = 1'b0; OP_READ = 1'b0; OP_WRITE = 1'b0; OP_PAUSE = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%h exp=0", BUSY); end
        n_cmp++; if (EBOX_REQ !== 1'b0) begin n_err++; $display("FAIL rst_req got=%h exp=0", EBOX_REQ); end
        n_cmp++; if (RD_DATA !== 36'o0) begin n_err++; $display("FAIL rst_rdata got=%o exp=0", RD_DATA); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rst_done got=%h exp=0", DONE); end
        RESET_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        start_ref(1'b1, 1'b0, 1'b0, 23'h001234);
        n_cmp++; if (EBOX_REQ !== 1'b1) begin n_err++; $display("FAIL rd_req got=%h exp=1", EBOX_REQ); end
        n_cmp++; if ({VMA_READ, VMA_WRITE, VMA_PAUSE} !== 3'b100) begin n_err++; $display("FAIL rd_qual got=%b exp=100", {VMA_READ, VMA_WRITE, VMA_PAUSE}); end
        n_cmp++; if (VMA_OUT !== 23'h001234) begin n_err++; $display("FAIL rd_vma got=%h exp=001234", VMA_OUT); end
        tick();
        // WAIT: respond, and try a START while busy
        MBOX_RESP = 1'b1; MB_RD_DATA = 36'o123456701234;
        START = 1'b1; OP_READ = 1'b1; VMA_IN = 23'h007777;
        n_cmp++; if (EBOX_REQ !== 1'b1) begin n_err++; $display("FAIL rd_req_wait got=%h exp=1", EBOX_REQ); end
        tick();
        MBOX_RESP = 1'b0; START = 1'b0; OP_READ = 1'b0;
        n_cmp++; if ({EBOX_SYNC, DONE} !== 2'b11) begin n_err++; $display("FAIL rd_sync_done got=%b exp=11", {EBOX_SYNC, DONE}); end
        n_cmp++; if (RD_DATA !== 36'o123456701234) begin n_err++; $display("FAIL rd_data got=%o exp=123456701234", RD_DATA); end
        n_cmp++; if (VMA_OUT !== 23'h001234) begin n_err++; $display("FAIL rd_busy_start got=%h exp=001234", VMA_OUT); end
        tick();
        n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_err++; $display("FAIL rd_idle got=%b exp=00", {BUSY, DONE}); end
    endtask

    task automatic test_pause();
        start_ref(1'b1, 1'b1, 1'b1, 23'h05a5a5);
        n_cmp++; if ({VMA_READ, VMA_WRITE, VMA_PAUSE} !== 3'b101) begin n_err++; $display("FAIL rpw_qual1 got=%b exp=101", {VMA_READ, VMA_WRITE, VMA_PAUSE}); end
        tick();
        MBOX_RESP = 1'b1; MB_RD_DATA = 36'o1;
        tick();
        MBOX_RESP = 1'b0;
        n_cmp++; if ({EBOX_SYNC, DONE} !== 2'b10) begin n_err++; $display("FAIL rpw_sync1 got=%b exp=10", {EBOX_SYNC, DONE}); end
        tick();
        VMA_IN = 23'h000bad;
        n_cmp++; if ({BUSY, EBOX_REQ} !== 2'b10) begin n_err++; $display("FAIL rpw_pause got=%b exp=10", {BUSY, EBOX_REQ}); end
        tick();
        WR_GO = 1'b1; WR_DATA = 36'o777;
        tick();
        WR_GO = 1'b0; WR_DATA = 36'o0;
        n_cmp++; if ({EBOX_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE} !== 4'b1010) begin n_err++; $display("FAIL rpw_qual2 got=%b exp=1010", {EBOX_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE}); end
        n_cmp++; if (EB_WR_DATA !== 36'o777) begin n_err++; $display("FAIL rpw_wdata got=%o exp=777", EB_WR_DATA); end
        n_cmp++; if (VMA_OUT !== 23'h05a5a5) begin n_err++; $display("FAIL rpw_vma got=%h exp=05a5a5", VMA_OUT); end
        tick();
        MBOX_RESP = 1'b1; MB_RD_DATA = 36'o5555;
        tick();
        MBOX_RESP = 1'b0;
        n_cmp++; if ({EBOX_SYNC, DONE} !== 2'b11) begin n_err++; $display("FAIL rpw_done got=%b exp=11", {EBOX_SYNC, DONE}); end
        n_cmp++; if (RD_DATA !== 36'o1) begin n_err++; $display("FAIL rpw_rdata got=%o exp=1", RD_DATA); end
        tick();
    endtask

    task automatic test_retry();
        start_ref(1'b1, 1'b0, 1'b0, 23'h000100);
        tick();
        for (int i = 1; i <= 2; i++) begin
            EBOX_RETRY_REQ = 1'b1;
            tick();
            EBOX_RETRY_REQ = 1'b0;
            n_cmp++; if (EBOX_REQ !== 1'b0) begin n_err++; $display("FAIL rty_gap%0d got=%h exp=0", i, EBOX_REQ); end
            n_cmp++; if (RETRY_CNT !== 4'(i)) begin n_err++; $display("FAIL rty_cnt%0d got=%0d exp=%0d", i, RETRY_CNT, i); end
            tick();
            n_cmp++; if (EBOX_REQ !== 1'b1) begin n_err++; $display("FAIL rty_reissue%0d got=%h exp=1", i, EBOX_REQ); end
            tick();
        end
        MBOX_RESP = 1'b1; MB_RD_DATA = 36'o246;
        tick();
        MBOX_RESP = 1'b0;
        n_cmp++; if ({EBOX_SYNC, DONE, RETRY_CNT} !== 6'b11_0010) begin n_err++; $display("FAIL rty_done got=%b exp=110010", {EBOX_SYNC, DONE, RETRY_CNT}); end
        n_cmp++; if (RD_DATA !== 36'o246) begin n_err++; $display("FAIL rty_rdata got=%o exp=246", RD_DATA); end
        tick();
    endtask

    task automatic test_retry_exhaust();
        start_ref(1'b1, 1'b0, 1'b0, 23'h000200);
        tick();
        for (int i = 0; i < 15; i++) begin
            EBOX_RETRY_REQ = 1'b1;
            tick();
            EBOX_RETRY_REQ = 1'b0;
            tick(); tick();
        end
        n_cmp++; if (RETRY_CNT !== 4'd15) begin n_err++; $display("FAIL rtx_cnt got=%0d exp=15", RETRY_CNT); end
        n_cmp++; if (NXM_ERR !== 1'b0) begin n_err++; $display("FAIL rtx_early got=%h exp=0", NXM_ERR); end
        EBOX_RETRY_REQ = 1'b1;
        tick();
        EBOX_RETRY_REQ = 1'b0;
        n_cmp++; if ({NXM_ERR, DONE, EBOX_REQ, EBOX_SYNC} !== 4'b1100) begin n_err++; $display("FAIL rtx_fail got=%b exp=1100", {NXM_ERR, DONE, EBOX_REQ, EBOX_SYNC}); end
        n_cmp++; if (RETRY_CNT !== 4'd15) begin n_err++; $display("FAIL rtx_sat got=%0d exp=15", RETRY_CNT); end
        tick();
        n_cmp++; if ({BUSY, NXM_ERR} !== 2'b01) begin n_err++; $display("FAIL rtx_sticky got=%b exp=01", {BUSY, NXM_ERR}); end
    endtask

    task automatic test_page_fail();
        start_ref(1'b1, 1'b0, 1'b0, 23'h000300);
        n_cmp++; if (NXM_ERR !== 1'b0) begin n_err++; $display("FAIL pf_nxm_clr got=%h exp=0", NXM_ERR); end
        tick();
        PAGE_FAIL_HOLD = 1'b1; MBOX_RESP = 1'b1; MB_RD_DATA = 36'o7070;
        tick();
        PAGE_FAIL_HOLD = 1'b0; MBOX_RESP = 1'b0;
        n_cmp++; if ({PAGE_FAIL, EBOX_SYNC, DONE} !== 3'b101) begin n_err++; $display("FAIL pf_fail got=%b exp=101", {PAGE_FAIL, EBOX_SYNC, DONE}); end
        tick();
        n_cmp++; if ({BUSY, PAGE_FAIL} !== 2'b01) begin n_err++; $display("FAIL pf_sticky got=%b exp=01", {BUSY, PAGE_FAIL}); end
    endtask

    task automatic test_timeout();
        WR_DATA = 36'o4321;
        start_ref(1'b0, 1'b1, 1'b0, 23'h000400);
        WR_DATA = 36'o0;
        n_cmp++; if ({VMA_WRITE, VMA_READ, PAGE_FAIL} !== 3'b100) begin n_err++; $display("FAIL tmo_qual got=%b exp=100", {VMA_WRITE, VMA_READ, PAGE_FAIL}); end
        n_cmp++; if (EB_WR_DATA !== 36'o4321) begin n_err++; $display("FAIL tmo_wdata got=%o exp=4321", EB_WR_DATA); end
        tick();
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if ({NXM_ERR, DONE, EBOX_REQ} !== 3'b001) begin n_err++; $display("FAIL tmo_wait%0d got=%b exp=001", i, {NXM_ERR, DONE, EBOX_REQ}); end
            tick();
        end
        n_cmp++; if ({NXM_ERR, DONE} !== 2'b11) begin n_err++; $display("FAIL tmo_nxm got=%b exp=11", {NXM_ERR, DONE}); end
        tick();
        start_ref(1'b0, 1'b0, 1'b0, 23'h0);
        n_cmp++; if ({DONE, NXM_ERR, BUSY, EBOX_REQ} !== 4'b1000) begin n_err++; $display("FAIL tmo_noop got=%b exp=1000", {DONE, NXM_ERR, BUSY, EBOX_REQ}); end
        tick();
    endtask

    task automatic test_abort();
        start_ref(1'b1, 1'b0, 1'b0, 23'h000500);
        tick();
        ABORT = 1'b1; MBOX_RESP = 1'b1; MB_RD_DATA = 36'o1111;
        tick();
        ABORT = 1'b0; MBOX_RESP = 1'b0;
        n_cmp++; if ({EBOX_CYC_ABORT, EBOX_SYNC, DONE, BUSY, EBOX_REQ} !== 5'b10000) begin n_err++; $display("FAIL abt_pulse got=%b exp=10000", {EBOX_CYC_ABORT, EBOX_SYNC, DONE, BUSY, EBOX_REQ}); end
        n_cmp++; if (RD_DATA !== 36'o246) begin n_err++; $display("FAIL abt_rdata got=%o exp=246", RD_DATA); end
        tick();
        n_cmp++; if ({EBOX_CYC_ABORT, DONE} !== 2'b00) begin n_err++; $display("FAIL abt_after got=%b exp=00", {EBOX_CYC_ABORT, DONE}); end
    endtask

    task automatic test_reset_mid();
        start_ref(1'b1, 1'b0, 1'b0, 23'h000600);
        tick();
        EBOX_RETRY_REQ = 1'b1;
        tick();
        EBOX_RETRY_REQ = 1'b0;
        tick(); tick();
        #2 RESET_n = 1'b0;
        #1;
        n_cmp++; if ({BUSY, EBOX_REQ, VMA_READ, DONE, EBOX_SYNC} !== 5'b0) begin n_err++; $display("FAIL rstm_ctl got=%b exp=00000", {BUSY, EBOX_REQ, VMA_READ, DONE, EBOX_SYNC}); end
        n_cmp++; if ({VMA_OUT, RD_DATA, EB_WR_DATA} !== '0) begin n_err++; $display("FAIL rstm_data got=%h/%o/%o exp=0", VMA_OUT, RD_DATA, EB_WR_DATA); end
        n_cmp++; if (RETRY_CNT !== 4'd0) begin n_err++; $display("FAIL rstm_cnt got=%0d exp=0", RETRY_CNT); end
        tick();
        RESET_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_pause();
        test_retry();
        test_retry_exhaust();
        test_page_fail();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
